mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 7 +
 rtl/mem_arbiter_rr_pick2.sv | 14 +
 rtl/mem_arbiter.sv | 93 +++++++++
 tb/tb_mem_arbiter.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared FSM states, grant encodings and RAM latency bounds for the arbiter.
package mem_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;
  typedef enum logic {GNT_I = 1'b0, GNT_D = 1'b1} gnt_e;
  localparam int RAM_LAT_MIN = 1;
  localparam int RAM_LAT_MAX = 15;
endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin pick; on a tie the requester not granted last wins.
module rr_pick2
  import mem_arbiter_pkg::*;
(
  input  logic       i_req_i,
  input  logic       d_req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);
  logic last_d;
  assign last_d   = (last_i == GNT_D);
  assign gnt_o[0] = i_req_i & (~d_req_i | last_d);
  assign gnt_o[1] = d_req_i & (~i_req_i | ~last_d);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM between an instruction-fetch port and a data port.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int RAM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic [31:0] Addr,
  output logic        R,
  output logic        W,
  output logic [31:0] W_data,
  input  logic [31:0] R_data
);
  localparam logic [3:0] LAT_M1 = 4'(RAM_LAT - 1);
  state_e      state_q;
  gnt_e        gnt_q, last_q;
  logic [3:0]  cnt_q;
  logic        r_q, w_q, i_ack_q, d_ack_q;
  logic [31:0] i_rdata_q, d_rdata_q, addr_q, wdata_q;
  logic [1:0]  pick;
  rr_pick2 u_pick (
    .i_req_i(i_req),
    .d_req_i(d_req),
    .last_i (last_q),
    .gnt_o  (pick)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= GNT_I;
      last_q    <= GNT_D;
      cnt_q     <= '0;
      r_q       <= 1'b0;
      w_q       <= 1'b0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (i_req | d_req) begin
          gnt_q   <= pick[1] ? GNT_D : GNT_I;
          last_q  <= pick[1] ? GNT_D : GNT_I;
          addr_q  <= pick[1] ? d_addr : i_addr;
          wdata_q <= pick[1] ? d_wdata : wdata_q;
          r_q     <= ~(pick[1] & d_we);
          w_q     <= pick[1] & d_we;
          cnt_q   <= LAT_M1;
          state_q <= ACCESS;
        end
        ACCESS: if (cnt_q == '0) begin
          // The RAM word is sampled on the edge that closes the strobe window
          i_rdata_q <= (r_q && gnt_q == GNT_I) ? R_data : i_rdata_q;
          d_rdata_q <= (r_q && gnt_q == GNT_D) ? R_data : d_rdata_q;
          r_q       <= 1'b0;
          w_q       <= 1'b0;
          i_ack_q   <= (gnt_q == GNT_I);
          d_ack_q   <= (gnt_q == GNT_D);
          state_q   <= DONE;
        end else begin
          cnt_q <= cnt_q - 4'd1;
        end
        DONE: begin
          i_ack_q <= 1'b0;
          d_ack_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign i_ack   = i_ack_q;
  assign d_ack   = d_ack_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign Addr    = addr_q;
  assign R       = r_q;
  assign W       = w_q;
  assign W_data  = wdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: three arbiters (RAM_LAT 1, 4, 3) on behavioural RAMs, checked against a scoreboard.
module tb_mem_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic [2:0]  rst, rst_q, i_req, d_req, d_we, i_ack, d_ack, R, W;
  logic [31:0] i_addr[3], d_addr[3], d_wdata[3], i_rdata[3], d_rdata[3], Addr[3], W_data[3], R_data[3];
  logic [31:0] mem[3][64];
  logic [31:0] m_ird[3], m_drd[3];
  logic        pl_en;
  int          pl_g, pl_a;
  logic [31:0] pl_d;
  int cyc = 0, errors = 0, checks = 0;
  int r_cyc[3], w_cyc[3];
  typedef struct {
    int g; bit is_d; bit we; logic [31:0] addr; logic [31:0] wdata; logic [31:0] data; int due;
  } exp_t;
  exp_t sb[$];
  exp_t em;
  function automatic int lat(int g);
    return g == 0 ? 1 : g == 1 ? 4 : 3;
  endfunction
  for (genvar g = 0; g < 3; g++) begin : inst
    mem_arbiter #(.RAM_LAT(g == 0 ? 1 : g == 1 ? 4 : 3)) dut (
      .clk(clk), .rst(rst[g]),
      .i_req(i_req[g]), .i_addr(i_addr[g]), .i_ack(i_ack[g]), .i_rdata(i_rdata[g]),
      .d_req(d_req[g]), .d_we(d_we[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
      .d_ack(d_ack[g]), .d_rdata(d_rdata[g]),
      .Addr(Addr[g]), .R(R[g]), .W(W[g]), .W_data(W_data[g]), .R_data(R_data[g])
    );
    assign R_data[g] = mem[g][Addr[g][7:2]];
  end
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
    for (int g = 0; g < 3; g++) if (W[g]) mem[g][Addr[g][7:2]] <= W_data[g];
    if (pl_en) mem[pl_g][pl_a] <= pl_d;
  end
  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    assert (!(|(R & W)));
    assert (!(|(i_ack & d_ack)));
    for (int g = 0; g < 3; g++) begin
      chk("no_rw_overlap", 32'(R[g] & W[g]), 0);
      chk("no_dual_ack", 32'(i_ack[g] & d_ack[g]), 0);
      if (rst_q[g]) begin
        m_ird[g] = '0;
        m_drd[g] = '0;
        chk("rst_ctl", 32'({R[g], W[g], i_ack[g], d_ack[g]}), 0);
        chk("rst_i_rdata", i_rdata[g], 0);
        chk("rst_d_rdata", d_rdata[g], 0);
        chk("rst_addr", Addr[g], 0);
        chk("rst_wdata", W_data[g], 0);
      end
      if (R[g]) r_cyc[g]++;
      if (W[g]) w_cyc[g]++;
      if (R[g] | W[g]) begin
        if (sb.size() == 0) chk("strobe_unexpected", 32'({R[g], W[g]}), 0);
        else begin
          chk("strobe_inst", 32'(g), 32'(sb[0].g));
          chk("strobe_addr", Addr[g], sb[0].addr);
          chk("strobe_kind", 32'({R[g], W[g]}), sb[0].we ? 32'd1 : 32'd2);
          if (sb[0].we) chk("strobe_wdata", W_data[g], sb[0].wdata);
        end
      end
      if (i_ack[g] | d_ack[g]) begin
        if (sb.size() == 0) chk("ack_unexpected", 32'({i_ack[g], d_ack[g]}), 0);
        else begin
          em = sb.pop_front();
          chk("ack_inst", 32'(g), 32'(em.g));
          chk("ack_who", 32'(d_ack[g]), 32'(em.is_d));
          chk("ack_cycle", 32'(cyc), 32'(em.due));
          if (!em.is_d) m_ird[g] = em.data;
          else if (!em.we) m_drd[g] = em.data;
        end
        chk("i_rdata", i_rdata[g], m_ird[g]);
        chk("d_rdata", d_rdata[g], m_drd[g]);
      end
    end
  end
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic poke(int g, logic [31:0] a, logic [31:0] d);
    pl_en = 1'b1; pl_g = g; pl_a = int'(a[7:2]); pl_d = d;
    tick(1);
    pl_en = 1'b0;
  endtask
  task automatic push(int g, bit is_d, bit we, logic [31:0] addr, logic [31:0] wdata,
                      logic [31:0] data, int due);
    exp_t e;
    e.g = g; e.is_d = is_d; e.we = we; e.addr = addr; e.wdata = wdata; e.data = data; e.due = due;
    sb.push_back(e);
  endtask
  task automatic issue(int g, bit is_d, bit we, logic [31:0] addr, logic [31:0] wdata,
                       logic [31:0] data);
    push(g, is_d, we, addr, wdata, data, cyc + 1 + lat(g));
    if (is_d) begin
      d_req[g] = 1'b1; d_we[g] = we; d_addr[g] = addr; d_wdata[g] = wdata;
    end else begin
      i_req[g] = 1'b1; i_addr[g] = addr;
    end
  endtask
  task automatic wait_idle(int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    if (sb.size() != 0) begin
      chk("timeout_pending", 32'(sb.size()), 0);
      sb.delete();
    end
    i_req = '0;
    d_req = '0;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int r0, w0, k;
    rst = 3'b111; i_req = '0; d_req = '0; d_we = '0; pl_en = 1'b0; pl_g = 0; pl_a = 0; pl_d = '0;
    for (int g = 0; g < 3; g++) begin
      i_addr[g] = '0; d_addr[g] = '0; d_wdata[g] = '0; m_ird[g] = '0; m_drd[g] = '0;
      r_cyc[g] = 0; w_cyc[g] = 0;
    end
    tick(3);
    rst = '0;
    poke(0, 32'h10, 32'hDEADBEEF);
    poke(0, 32'h30, 32'h0000_000A);
    poke(0, 32'h34, 32'h0000_000B);
    poke(1, 32'h08, 32'h0000_1234);
    poke(2, 32'h04, 32'h0000_0077);
    r0 = r_cyc[0];
    issue(0, 1'b0, 1'b0, 32'h10, 0, 32'hDEADBEEF);
    wait_idle(20);
    chk("s1_r_cycles", 32'(r_cyc[0] - r0), 1);
    w0 = w_cyc[0];
    issue(0, 1'b1, 1'b1, 32'h20, 32'h5, 0);
    wait_idle(20);
    chk("s2_w_cycles", 32'(w_cyc[0] - w0), 1);
    issue(0, 1'b1, 1'b0, 32'h20, 0, 32'h5);
    wait_idle(20);
    k = cyc;
    i_req[0] = 1'b1; i_addr[0] = 32'h30;
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h34;
    push(0, 1'b0, 1'b0, 32'h30, 0, 32'hA, k + 2);
    push(0, 1'b1, 1'b0, 32'h34, 0, 32'hB, k + 5);
    push(0, 1'b0, 1'b0, 32'h30, 0, 32'hA, k + 8);
    push(0, 1'b1, 1'b0, 32'h34, 0, 32'hB, k + 11);
    wait_idle(40);
    r0 = r_cyc[1];
    issue(1, 1'b1, 1'b0, 32'h08, 0, 32'h1234);
    wait_idle(30);
    chk("s4_r_cycles", 32'(r_cyc[1] - r0), 4);
    issue(2, 1'b1, 1'b0, 32'h04, 0, 32'h77);
    tick(2);
    rst[2] = 1'b1;
    d_req[2] = 1'b0;
    tick(1);
    sb.delete();
    rst[2] = 1'b0;
    tick(8);
    issue(2, 1'b0, 1'b0, 32'h04, 0, 32'h77);
    wait_idle(30);
    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
